// File: rtl/csa_pkg.sv
// Shared types and constants for the stream cipher controller.
package csa_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    INIT = 3'd2,
    GEN  = 3'd3,
    HOLD = 3'd4
  } state_t;

  localparam int GEN_ROUNDS = 32;
  localparam int KS_W       = 64;

endpackage

// File: rtl/ks_packer.sv
// Keystream collector: shifts 2-bit core output pairs in MSB-first.
module ks_packer
  import csa_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            shift_en,
  input  logic [1:0]      bits_in,
  output logic [KS_W-1:0] data_out
);

  always_ff @(posedge clk) begin
    if (rst || clr) data_out <= '0;
    else if (shift_en) data_out <= {data_out[KS_W-3:0], bits_in};
  end

endmodule

// File: rtl/stream_cipher_ctrl.sv
// Sequencer for a stream cipher core: key load, init rounds, keystream block generation.
// Optional block handshake counter enabled with `define CSA_CTRL_BLK_CNT_EN.
module stream_cipher_ctrl
  import csa_pkg::*;
#(
  parameter int ROUNDS_PER_BYTE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_init,
  input  logic            start_gen,
  input  logic [KS_W-1:0] init_block,
  output logic            idle,
  output logic            core_load,
  output logic            core_en,
  output logic            core_init,
  output logic [7:0]      core_din,
  input  logic [1:0]      core_bits,
  output logic [KS_W-1:0] ks_data,
  output logic            ks_valid,
  input  logic            ks_ready,
  output logic            err
`ifdef CSA_CTRL_BLK_CNT_EN
  ,
  output logic [15:0]     blk_cnt
`endif
);

  localparam int INIT_ROUNDS = 8 * ROUNDS_PER_BYTE;
  localparam int MAX_ROUNDS  = (INIT_ROUNDS > GEN_ROUNDS) ? INIT_ROUNDS : GEN_ROUNDS;
  localparam int CNT_W       = (MAX_ROUNDS > 8) ? $clog2(MAX_ROUNDS) : 3;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  rnd_cnt;
  logic [CNT_W-1:0]  byte_idx;
  logic [KS_W-1:0]   init_q;
  logic              init_done;
  logic              err_q;
  logic              acc_init, acc_gen, rej_gen, last_rnd;

  // start_init has priority; start_gen needs a completed init to be valid
  always_comb begin
    acc_init = (state == IDLE) && start_init;
    acc_gen  = (state == IDLE) && start_gen && !start_init && init_done;
    rej_gen  = (state == IDLE) && start_gen && !start_init && !init_done;
    last_rnd = ((state == INIT) && (rnd_cnt == CNT_W'(INIT_ROUNDS - 1))) ||
               ((state == GEN)  && (rnd_cnt == CNT_W'(GEN_ROUNDS - 1)));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    idle      = 1'b0;
    core_load = 1'b0;
    core_en   = 1'b0;
    core_init = 1'b0;
    ks_valid  = 1'b0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (acc_init)     state_nx = LOAD;
        else if (acc_gen) state_nx = GEN;
      end
      LOAD: begin
        core_load = 1'b1;
        state_nx  = INIT;
      end
      INIT: begin
        core_en   = 1'b1;
        core_init = 1'b1;
        if (last_rnd) state_nx = GEN;
      end
      GEN: begin
        core_en = 1'b1;
        if (last_rnd) state_nx = HOLD;
      end
      HOLD: begin
        ks_valid = 1'b1;
        if (ks_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One counter serves both phases; it returns to zero on each phase's last round
  always_ff @(posedge clk) begin
    if (rst)          rnd_cnt <= '0;
    else if (core_en) rnd_cnt <= last_rnd ? '0 : rnd_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)           init_q <= '0;
    else if (acc_init) init_q <= init_block;
  end

  always_ff @(posedge clk) begin
    if (rst)                                init_done <= 1'b0;
    else if (state == LOAD)                 init_done <= 1'b0;
    else if ((state == INIT) && last_rnd)   init_done <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= rej_gen;
  end

  assign err      = err_q;
  assign byte_idx = rnd_cnt / CNT_W'(ROUNDS_PER_BYTE);

  // Byte 0 is the most significant byte of the latched init block
  always_comb begin
    core_din = '0;
    if (state == INIT) begin
      for (int b = 0; b < 8; b++)
        if (byte_idx == CNT_W'(b)) core_din = init_q[KS_W-1-8*b -: 8];
    end
  end

  ks_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == LOAD),
    .shift_en (state == GEN),
    .bits_in  (core_bits),
    .data_out (ks_data)
  );

`ifdef CSA_CTRL_BLK_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || acc_init)          blk_cnt <= '0;
    else if (ks_valid && ks_ready) blk_cnt <= blk_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_stream_cipher_ctrl.sv
// Self-checking bench for stream_cipher_ctrl: directed cases plus randomized sequences.
module tb_stream_cipher_ctrl;

  localparam int RPB    = 4;
  localparam int INIT_R = 8 * RPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_init, start_gen;
  logic [63:0] init_block;
  logic        idle, core_load, core_en, core_init;
  logic [7:0]  core_din;
  logic [1:0]  core_bits;
  logic [63:0] ks_data;
  logic        ks_valid, ks_ready, err;
`ifdef CSA_CTRL_BLK_CNT_EN
  logic [15:0] blk_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  stream_cipher_ctrl #(.ROUNDS_PER_BYTE(RPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_init (start_init),
    .start_gen  (start_gen),
    .init_block (init_block),
    .idle       (idle),
    .core_load  (core_load),
    .core_en    (core_en),
    .core_init  (core_init),
    .core_din   (core_din),
    .core_bits  (core_bits),
    .ks_data    (ks_data),
    .ks_valid   (ks_valid),
    .ks_ready   (ks_ready),
    .err        (err)
`ifdef CSA_CTRL_BLK_CNT_EN
    ,
    .blk_cnt    (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction, cycle 0 = the accepting cycle. The expected keystream is
  // assembled from the list of pairs the bench fed: pair i occupies bits [63-2i:62-2i].
  task automatic run_seq(input bit is_init, input logic [63:0] blk, input bit rnd,
                         input logic [1:0] fix, input int hold);
    logic [1:0]  p [32];
    logic [63:0] exp_ks;
    int          k;
    chk("idle_c0", idle, 1);
    if (is_init) begin start_init = 1; init_block = blk; end
    else start_gen = 1;
    tick;
    start_init = 0; start_gen = 0; init_block = {$urandom, $urandom};
    if (is_init) begin
      chk("load_c1", {core_load, core_en}, 2'b10);
      for (int c = 2; c < 2 + INIT_R; c++) begin
        tick;
        k = (c - 2) / RPB;
        chk("init_en", {core_en, core_init, core_load}, 3'b110);
        chk("init_din", core_din, blk[63-8*k -: 8]);
      end
      tick;
    end
    for (int i = 0; i < 32; i++) begin
      p[i] = rnd ? 2'($urandom) : fix;
      core_bits = p[i];
      chk("gen_en", {core_en, core_init, ks_valid, idle}, 4'b1000);
      tick;
    end
    exp_ks = '0;
    for (int i = 0; i < 32; i++) exp_ks[63-2*i -: 2] = p[i];
    core_bits = 2'($urandom);
    for (int h = 0; h < hold; h++) begin
      chk("hold_vld", {ks_valid, idle, core_en, core_load, err}, 5'b10000);
      chk("hold_data", ks_data, exp_ks);
      start_init = h[0]; start_gen = ~h[0];
      tick;
      start_init = 0; start_gen = 0;
    end
    chk("ks_valid", ks_valid, 1);
    chk("ks_data", ks_data, exp_ks);
    ks_ready = 1;
    tick;
    ks_ready = 0;
    chk("back_idle", {idle, ks_valid, err, core_load}, 4'b1000);
  endtask

  task automatic do_reset;
    rst = 1;
    tick;
    chk("rst_idle", idle, 1);
    chk("rst_outs", {core_load, core_en, core_init, core_din, ks_valid, err}, '0);
    chk("rst_ks", ks_data, '0);
    rst = 0;
  endtask

  task automatic gen_rejected(input string tag);
    start_gen = 1;
    tick;
    start_gen = 0;
    chk({tag, "_err"}, {err, idle, core_en}, 3'b110);
    tick;
    chk({tag, "_err_off"}, {err, idle, core_en}, 3'b010);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; start_init = 0; start_gen = 0; init_block = '0;
    core_bits = '0; ks_ready = 0;
    tick;
    do_reset;

    gen_rejected("gen_no_init");

    run_seq(1, 64'h0011223344556677, 0, 2'b10, 0);
    run_seq(0, 64'h0, 0, 2'b01, 10);

    for (int t = 0; t < 3; t++) begin
      run_seq(1, {$urandom, $urandom}, 1, 2'b00, int'($urandom_range(0, 3)));
      run_seq(0, 64'h0, 1, 2'b00, int'($urandom_range(0, 3)));
    end

    // Simultaneous starts pick init, then reset lands mid-INIT
    start_init = 1; start_gen = 1; init_block = {$urandom, $urandom};
    tick;
    start_init = 0; start_gen = 0;
    chk("both_load", {core_load, err, idle}, 3'b100);
    for (int c = 0; c < 21; c++) tick;
    chk("mid_init", {core_en, core_init}, 2'b11);
    rst = 1;
    tick;
    rst = 0;
    chk("rst_mid_idle", {idle, core_en, core_init, core_load, ks_valid}, 5'b10000);
    chk("rst_mid_ks", ks_data, '0);
    gen_rejected("gen_after_rst");

`ifdef CSA_CTRL_BLK_CNT_EN
    do_reset;
    chk("cnt_rst", blk_cnt, 0);
    run_seq(1, {$urandom, $urandom}, 1, 2'b00, 1);
    run_seq(0, 64'h0, 1, 2'b00, 0);
    run_seq(0, 64'h0, 1, 2'b00, 2);
    chk("cnt_three", blk_cnt, 3);
    start_init = 1;
    tick;
    start_init = 0;
    chk("cnt_clr", blk_cnt, 0);
    do_reset;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
